// File: rtl/timer_irq_6502.sv
// Memory-mapped 16-bit interval timer for the 6502 bus: prescaled down-counter
// with reload, one-shot/continuous modes, a status flag and an active-low irq.
module timer_irq_6502 #(
  parameter logic [15:0] BASE     = 16'hD000,
  parameter int unsigned PRESCALE = 16
) (
  input  logic        eclk,
  input  logic        ereset,
  input  logic [15:0] ab,
  input  logic [7:0]  db_o,
  input  logic        rw,
  input  logic        clk2out,
  output logic [7:0]  db_i,
  output logic        db_sel,
  output logic        irq
);

  localparam int unsigned   PW      = $clog2(PRESCALE);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    REG_CNT_LO = 2'd0,
    REG_CNT_HI = 2'd1,
    REG_CTRL   = 2'd2,
    REG_STATUS = 2'd3
  } reg_off_e;

  logic          c2_d;
  logic [15:0]   reload, count;
  logic [2:0]    ctrl;       // {ONESHOT, IE, EN}
  logic          flag;
  logic [7:0]    hi_latch;
  logic [PW-1:0] prescaler;

  logic [15:0]   reload_n, count_n;
  logic [2:0]    ctrl_n;
  logic          flag_n;
  logic [7:0]    hi_latch_n;
  logic [PW-1:0] prescaler_n;
  logic [7:0]    rdata;

  reg_off_e off;
  logic     hit, commit, wrap, tick, expire;
  logic     wr_lo, wr_hi, wr_ctrl, wr_status, rd_lo, rd_status;

  assign off    = reg_off_e'(ab[1:0]);
  assign hit    = (ab[15:2] == BASE[15:2]);
  assign db_sel = hit & rw;

  // A bus cycle commits once, on the eclk where phi2 is seen falling.
  assign commit    = hit & c2_d & ~clk2out;
  assign wr_lo     = commit & ~rw & (off == REG_CNT_LO);
  assign wr_hi     = commit & ~rw & (off == REG_CNT_HI);
  assign wr_ctrl   = commit & ~rw & (off == REG_CTRL);
  assign wr_status = commit & ~rw & (off == REG_STATUS);
  assign rd_lo     = commit &  rw & (off == REG_CNT_LO);
  assign rd_status = commit &  rw & (off == REG_STATUS);

  // A CNT_HI load swallows a coincident tick so the loaded value is exact.
  assign wrap   = ctrl[0] & (prescaler == PS_LAST);
  assign tick   = wrap & ~wr_hi;
  assign expire = tick & (count == 16'd0);

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    reload_n    = reload;
    count_n     = count;
    ctrl_n      = ctrl;
    flag_n      = flag;
    hi_latch_n  = hi_latch;
    prescaler_n = prescaler;
    rdata       = 8'h00;

    if (wr_lo) reload_n[7:0] = db_o;

    if (wr_hi) begin
      reload_n[15:8] = db_o;
      count_n        = {db_o, reload[7:0]};
    end else if (tick) begin
      if (count != 16'd0) count_n = count - 16'd1;
      else if (!ctrl[2])  count_n = reload;
    end

    if (wr_hi)        prescaler_n = '0;
    else if (ctrl[0]) prescaler_n = wrap ? '0 : prescaler + PW'(1);

    // Later assignments win: CTRL write over one-shot EN clear, set over clear.
    if (expire && ctrl[2]) ctrl_n[0] = 1'b0;
    if (wr_ctrl)           ctrl_n    = db_o[2:0];

    if (rd_status || (wr_status && db_o[0])) flag_n = 1'b0;
    if (expire)                              flag_n = 1'b1;

    if (rd_lo) hi_latch_n = count[15:8];

    if (db_sel) begin
      case (off)
        REG_CNT_LO: rdata = count[7:0];
        REG_CNT_HI: rdata = hi_latch;
        REG_CTRL:   rdata = {5'b0, ctrl};
        REG_STATUS: rdata = {7'b0, flag};
        default:    rdata = 8'h00;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge eclk or negedge ereset) begin
    if (!ereset) begin
      c2_d      <= 1'b0;
      reload    <= 16'h0000;
      count     <= 16'h0000;
      ctrl      <= 3'b000;
      flag      <= 1'b0;
      hi_latch  <= 8'h00;
      prescaler <= '0;
      db_i      <= 8'h00;
      irq       <= 1'b1;
    end else begin
      c2_d      <= clk2out;
      reload    <= reload_n;
      count     <= count_n;
      ctrl      <= ctrl_n;
      flag      <= flag_n;
      hi_latch  <= hi_latch_n;
      prescaler <= prescaler_n;
      db_i      <= rdata;
      irq       <= ~(flag & ctrl[1]);
    end
  end

endmodule

// File: tb/tb_timer_irq_6502.sv
// Self-checking bench for timer_irq_6502: reset/decode vector table plus
// hand-timed sequences for expiry, one-shot, coherent reads and collisions.
module tb_timer_irq_6502;

  logic        eclk = 1'b0;
  logic        ereset;
  logic [15:0] ab;
  logic [7:0]  db_o;
  logic        rw;
  logic        clk2out;
  logic [7:0]  db_i;
  logic        db_sel;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  timer_irq_6502 #(.BASE(16'hD000), .PRESCALE(16)) dut (
    .eclk    (eclk),
    .ereset  (ereset),
    .ab      (ab),
    .db_o    (db_o),
    .rw      (rw),
    .clk2out (clk2out),
    .db_i    (db_i),
    .db_sel  (db_sel),
    .irq     (irq)
  );

  always #5 eclk = ~eclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string      name;
    logic [7:0] data;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    logic [15:0] addr;
    logic        is_read;
    logic [7:0]  wdata;
    logic        exp_sel;
    logic [7:0]  exp_data;
    string       name;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One 6502 bus cycle: phi2 high for one eclk, then low; commit on the next edge.
  task automatic bus_cycle(input logic [15:0] addr, input logic is_read, input logic [7:0] wdata,
                           input logic exp_sel, input logic [7:0] exp_data, input string name);
    exp_t e;
    @(negedge eclk);
    ab      = addr;
    rw      = is_read;
    db_o    = wdata;
    clk2out = 1'b1;
    sb_q.push_back('{name, exp_data});
    @(negedge eclk);
    check({name, ".sel"}, 16'(db_sel), 16'(exp_sel));
    clk2out = 1'b0;
    @(posedge eclk);
    #1;
    e = sb_q.pop_front();
    check({e.name, ".data"}, 16'(db_i), 16'(e.data));
    ab   = 16'h0000;
    rw   = 1'b1;
    db_o = 8'h00;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] data);
    bus_cycle(addr, 1'b0, data, 1'b0, 8'h00, $sformatf("wr_%h", addr));
  endtask

  task automatic rd(input logic [15:0] addr, input logic [7:0] exp, input string name);
    bus_cycle(addr, 1'b1, 8'h00, 1'b1, exp, name);
  endtask

  task automatic tick_wait(input int n);
    repeat (n) @(posedge eclk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{16'hD000, 1'b1, 8'h00, 1'b1, 8'h00, "rst_cnt_lo"};
    vecs[1]  = '{16'hD001, 1'b1, 8'h00, 1'b1, 8'h00, "rst_cnt_hi"};
    vecs[2]  = '{16'hD002, 1'b1, 8'h00, 1'b1, 8'h00, "rst_ctrl"};
    vecs[3]  = '{16'hD003, 1'b1, 8'h00, 1'b1, 8'h00, "rst_status"};
    vecs[4]  = '{16'hCFFF, 1'b1, 8'h00, 1'b0, 8'h00, "rd_base_m1"};
    vecs[5]  = '{16'hD004, 1'b1, 8'h00, 1'b0, 8'h00, "rd_base_p4"};
    vecs[6]  = '{16'hCFFF, 1'b0, 8'h07, 1'b0, 8'h00, "wr_base_m1"};
    vecs[7]  = '{16'hD004, 1'b0, 8'h05, 1'b0, 8'h00, "wr_base_p4"};
    vecs[8]  = '{16'hCFFE, 1'b0, 8'h07, 1'b0, 8'h00, "wr_cffe"};
    vecs[9]  = '{16'hD006, 1'b0, 8'h07, 1'b0, 8'h00, "wr_d006"};
    vecs[10] = '{16'hD002, 1'b1, 8'h00, 1'b1, 8'h00, "ctrl_untouched"};
    vecs[11] = '{16'hD000, 1'b1, 8'h00, 1'b1, 8'h00, "cnt_untouched"};

    ereset  = 1'b0;
    ab      = 16'h0000;
    db_o    = 8'h00;
    rw      = 1'b1;
    clk2out = 1'b0;

    // Reset state
    #23;
    check("reset_irq", 16'(irq), 16'h1);
    check("reset_db_sel", 16'(db_sel), 16'h0);
    check("reset_db_i", 16'(db_i), 16'h0);
    @(negedge eclk);
    ereset = 1'b1;

    // Reset readback and address decode
    for (int i = 0; i < 12; i++)
      bus_cycle(vecs[i].addr, vecs[i].is_read, vecs[i].wdata,
                vecs[i].exp_sel, vecs[i].exp_data, vecs[i].name);

    // Continuous mode: count 3, ticks at +16/+32/+48, expiry at +64
    wr(16'hD000, 8'h03);
    wr(16'hD001, 8'h00);
    wr(16'hD002, 8'h03);
    tick_wait(64);
    check("cont_irq_before", 16'(irq), 16'h1);
    tick_wait(1);
    check("cont_irq_fall", 16'(irq), 16'h0);
    rd(16'hD000, 8'h03, "cont_reloaded");
    rd(16'hD003, 8'h01, "cont_status");
    check("cont_irq_hold", 16'(irq), 16'h0);
    tick_wait(1);
    check("cont_irq_rise", 16'(irq), 16'h1);

    // One-shot: count 1, expiry on the second tick
    wr(16'hD002, 8'h00);
    wr(16'hD000, 8'h01);
    wr(16'hD001, 8'h00);
    wr(16'hD002, 8'h07);
    tick_wait(32);
    check("os_irq_before", 16'(irq), 16'h1);
    tick_wait(1);
    check("os_irq_fall", 16'(irq), 16'h0);
    rd(16'hD002, 8'h06, "os_ctrl_en_cleared");
    rd(16'hD000, 8'h00, "os_cnt_lo");
    rd(16'hD001, 8'h00, "os_cnt_hi");
    wr(16'hD003, 8'h01);
    check("os_irq_hold", 16'(irq), 16'h0);
    tick_wait(1);
    check("os_irq_rise", 16'(irq), 16'h1);
    tick_wait(100);
    rd(16'hD003, 8'h00, "os_no_refire");
    check("os_irq_idle", 16'(irq), 16'h1);

    // Coherent 16-bit read across a 0100 -> 00FF tick
    wr(16'hD002, 8'h00);
    wr(16'hD000, 8'h00);
    wr(16'hD001, 8'h01);
    wr(16'hD002, 8'h01);
    rd(16'hD000, 8'h00, "coh_lo");
    tick_wait(20);
    rd(16'hD001, 8'h01, "coh_hi_latched");
    rd(16'hD000, 8'hFF, "coh_lo_after_tick");
    rd(16'hD001, 8'h00, "coh_hi_after_tick");

    // STATUS clear coinciding with an expiry tick: flag stays set
    wr(16'hD002, 8'h00);
    wr(16'hD003, 8'h01);
    wr(16'hD000, 8'h00);
    wr(16'hD001, 8'h00);
    wr(16'hD002, 8'h01);
    tick_wait(14);
    wr(16'hD003, 8'h01);
    rd(16'hD003, 8'h01, "sim_flag_set_wins");
    tick_wait(14);
    rd(16'hD003, 8'h01, "reload0_every_tick");

    // CNT_HI load coinciding with a tick: load wins, prescaler restarts
    wr(16'hD002, 8'h00);
    wr(16'hD000, 8'h10);
    wr(16'hD001, 8'h00);
    wr(16'hD002, 8'h01);
    tick_wait(14);
    wr(16'hD001, 8'h02);
    rd(16'hD000, 8'h10, "sim_load_lo");
    rd(16'hD001, 8'h02, "sim_load_hi");
    tick_wait(12);
    rd(16'hD000, 8'h0F, "sim_first_tick_after_load");

    // Asynchronous reset mid-count
    wr(16'hD002, 8'h00);
    wr(16'hD000, 8'h00);
    wr(16'hD001, 8'h00);
    wr(16'hD002, 8'h03);
    tick_wait(20);
    check("pre_reset_irq", 16'(irq), 16'h0);
    ab = 16'hD002;
    rw = 1'b1;
    tick_wait(1);
    check("pre_reset_db_i", 16'(db_i), 16'h03);
    #2;
    ereset = 1'b0;
    #1;
    check("async_reset_irq", 16'(irq), 16'h1);
    check("async_reset_db_i", 16'(db_i), 16'h00);
    ab = 16'h0000;
    @(negedge eclk);
    ereset = 1'b1;
    rd(16'hD002, 8'h00, "post_reset_ctrl");
    rd(16'hD003, 8'h00, "post_reset_status");
    tick_wait(40);
    check("post_reset_irq_idle", 16'(irq), 16'h1);
    rd(16'hD000, 8'h00, "post_reset_cnt");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
